keypad_scan_debounce: RTL

KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_scan_debounce_if.sv | 24 ++
 rtl/key_event_fifo.sv | 68 ++++++
 rtl/keypad_scan_debounce.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared constants and helpers for the keypad scanner.
//   Column one-hot drive patterns, event byte layout (CODE_W, KEY_REL_BIT),
//   parameter defaults, the column index type and a lowest-set-bit encoder.
package keypad_pkg;

  localparam int CODE_W           = 4;
  localparam int KEY_REL_BIT      = 7;
  localparam int SCAN_DIV_DEF     = 100000;
  localparam int DEBOUNCE_CNT_DEF = 4;
  localparam int FIFO_DEPTH_DEF   = 4;

  // Divider is wide enough for SCAN_DIV up to 2^20; stable counter for up to 15.
  localparam int DIV_W = 20;
  localparam int CNT_W = 4;

  localparam logic [3:0] COL0_DRV = 4'b1110;
  localparam logic [3:0] COL1_DRV = 4'b1101;
  localparam logic [3:0] COL2_DRV = 4'b1011;
  localparam logic [3:0] COL3_DRV = 4'b0111;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_idx_e;

  function automatic logic [3:0] col_drive(input col_idx_e idx);
    case (idx)
      COL0:    return COL0_DRV;
      COL1:    return COL1_DRV;
      COL2:    return COL2_DRV;
      default: return COL3_DRV;
    endcase
  endfunction

  // Index of the lowest set bit; 0 when no bit is set (callers gate on |bits).
  function automatic logic [CODE_W-1:0] lowest_code(input logic [15:0] bits);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (bits[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// keypad_scan_debounce_if -- host-side key event port of the keypad scanner.
//   key_read_ack     : single-cycle pop of the head event (host -> keypad)
//   key_overflow_clr : clears the sticky overflow flag     (host -> keypad)
//   key_data[7:0]    : head event byte, show-ahead, 8'h00 when empty
//   key_present      : event queue not empty
//   key_overflow     : sticky, an event was dropped
// master = host (PicoBlaze port decode), slave = keypad_scan_debounce.
interface keypad_scan_debounce_if;
  logic       key_read_ack;
  logic       key_overflow_clr;
  logic [7:0] key_data;
  logic       key_present;
  logic       key_overflow;

  modport master (
    output key_read_ack, key_overflow_clr,
    input  key_data, key_present, key_overflow
  );

  modport slave (
    input  key_read_ack, key_overflow_clr,
    output key_data, key_present, key_overflow
  );
endinterface

// File: rtl/key_event_fifo.sv
// key_event_fifo -- show-ahead event queue with count-based full/empty and a
// sticky overflow flag.
//   clk, pb_reset (async, active-high)
//   push, push_data : enqueue request; dropped (and flagged) when full unless
//                     a pop happens in the same clk
//   pop             : dequeue head; ignored when empty
//   overflow_clr    : clears overflow; a simultaneous drop wins
//   head_data       : head entry, reads 0 when empty
//   empty, overflow
// DEPTH must be a power of two, 2 or larger.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         pb_reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         overflow_clr,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_pop, do_push, drop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same clk frees the slot, so a push into a full queue still lands.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign head_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; count alone decides which entries are visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce -- 4x4 keypad column scanner with full-matrix debounce
// and a key event queue for a PicoBlaze port.
//   clk, pb_reset (async, active-high)
//   row[3:0] : row sense, active-low, asynchronous to clk
//   col[3:0] : column drive, one-hot active-low, 1110 -> 1101 -> 1011 -> 0111
//   host     : keypad_scan_debounce_if.slave (ack, data, present, overflow)
// Snapshot/debounced bit index = col_index*4 + row_index, 1 = pressed.
// Press events are {4'b0000, code}; only the lowest newly pressed key per
// debounced update is queued.
// Build option KEYPAD_RELEASE_EVT_EN: also queue release events
// {1'b1, 3'b000, code}, lowest index only, ahead of a same-update press.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       pb_reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  keypad_scan_debounce_if.slave host
);

  // ---------------------------------------------------------------- sync
  logic [3:0] row_meta, row_sync;

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      // NOTE: non-blocking, so row_sync takes last cycle's row_meta: two real stages.
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------- scan
  logic [DIV_W-1:0] div_cnt;
  logic             dwell_end, scan_done;
  col_idx_e         col_q, col_d;

  assign dwell_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_done = dwell_end && (col_q == COL3);

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) div_cnt <= '0;
    else if (dwell_end) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) col_q <= COL0;
    else col_q <= col_d;
  end

  // NOTE: col_d gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    col_d = col_q;
    if (dwell_end) col_d = col_idx_e'(2'(col_q + 2'd1));
  end

  assign col = col_drive(col_q);

  // ---------------------------------------------------------------- sample
  logic [15:0] snap_work, full_snap, prev_snap;

  // Column 3 is still in row_sync on the completion clk; splice it in directly.
  assign full_snap = {~row_sync, snap_work[11:0]};

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) snap_work <= '0;
    else if (dwell_end) snap_work[int'(col_q)*4 +: 4] <= ~row_sync;
  end

  // ---------------------------------------------------------------- debounce
  logic [CNT_W-1:0] stable_cnt;
  logic [15:0]      deb_state;
  logic             load_en;

  assign load_en = (stable_cnt == CNT_W'(DEBOUNCE_CNT));

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      prev_snap  <= '0;
      stable_cnt <= '0;
    end else if (scan_done) begin
      prev_snap <= full_snap;
      if (full_snap != prev_snap) stable_cnt <= '0;
      else if (!load_en)          stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Reloading while saturated is harmless: prev_snap only changes together
  // with a counter clear, so the reload after acceptance repeats the same value.
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) deb_state <= '0;
    else if (load_en) deb_state <= prev_snap;
  end

  // ---------------------------------------------------------------- events
  logic [15:0]       rise;
  logic              press_pend;
  logic [CODE_W-1:0] press_code;
  logic              push;
  logic [7:0]        push_data;

  assign rise = load_en ? (prev_snap & ~deb_state) : '0;

`ifdef KEYPAD_RELEASE_EVT_EN
  logic [15:0]       fall;
  logic              rel_pend;
  logic [CODE_W-1:0] rel_code;

  assign fall = load_en ? (deb_state & ~prev_snap) : '0;

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      rel_pend <= 1'b0;
      rel_code <= '0;
    end else if (|fall) begin
      rel_pend <= 1'b1;
      rel_code <= lowest_code(fall);
    end else begin
      rel_pend <= 1'b0;
    end
  end
`endif

  // The pending press is pushed on the clk after the debounced update; with
  // release events enabled it waits one more clk behind a pending release.
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      press_pend <= 1'b0;
      press_code <= '0;
    end else if (|rise) begin
      press_pend <= 1'b1;
      press_code <= lowest_code(rise);
    end else begin
`ifdef KEYPAD_RELEASE_EVT_EN
      if (!rel_pend) press_pend <= 1'b0;
`else
      press_pend <= 1'b0;
`endif
    end
  end

  always_comb begin
    push                      = press_pend;
    push_data                 = '0;
    push_data[CODE_W-1:0]     = press_code;
`ifdef KEYPAD_RELEASE_EVT_EN
    if (rel_pend) begin
      push                   = 1'b1;
      push_data              = '0;
      push_data[KEY_REL_BIT] = 1'b1;
      push_data[CODE_W-1:0]  = rel_code;
    end
`endif
  end

  // ---------------------------------------------------------------- queue
  logic fifo_empty;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk          (clk),
    .pb_reset     (pb_reset),
    .push         (push),
    .push_data    (push_data),
    .pop          (host.key_read_ack),
    .overflow_clr (host.key_overflow_clr),
    .head_data    (host.key_data),
    .empty        (fifo_empty),
    .overflow     (host.key_overflow)
  );

  assign host.key_present = ~fifo_empty;

endmodule
